// File: rtl/async_receiver.sv
// UART receiver: 8N1 (one or more stop bits), oversampled with 3-sample majority vote per bit.
// Delivers a one-cycle strobe per good byte, flags framing errors, and reports busy/idle line status.
module async_receiver #(
  parameter int clk_freq     = 25000000,
  parameter int baud         = 115200,
  parameter int oversampling = 8,
  parameter int idle_bits    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rxd_data,
  output logic       rxd_data_ready,
  output logic       rxd_framing_err,
  output logic       rxd_busy,
  output logic       rxd_idle
);

  localparam int OSR_RATE = baud * oversampling;
  localparam int DIV_RAW  = (clk_freq + OSR_RATE / 2) / OSR_RATE;
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W    = $clog2(DIV + 1);
  localparam int OS_W     = $clog2(oversampling);
  localparam int IDLE_MAX = idle_bits * oversampling;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(oversampling - 1);
  localparam logic [OS_W-1:0]   SMP_LO   = OS_W'(oversampling / 2 - 1);
  localparam logic [OS_W-1:0]   SMP_MID  = OS_W'(oversampling / 2);
  localparam logic [OS_W-1:0]   SMP_HI   = OS_W'(oversampling / 2 + 1);
  localparam logic [IDLE_W-1:0] IDLE_TOP = IDLE_W'(IDLE_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rxd_s;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [OS_W-1:0]     tcnt_q, tcnt_d;
  logic [OS_W-1:0]     idx;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [7:0]          data_q, data_d;
  logic                ready_q, ready_d;
  logic                ferr_q, ferr_d;
  logic                idle_q, idle_d;
  logic                smp_lo_q, smp_mid_q;
  logic [7:0]          shift_q;
  logic                tick;
  logic                decide;
  logic                maj;

  assign rxd_s = sync_q[1];
  assign tick  = (div_q == DIV_LAST);
  // Index of the tick now firing; the start edge itself counts as index 0.
  assign idx   = (tcnt_q == OS_LAST) ? '0 : tcnt_q + 1'b1;
  assign maj   = (smp_lo_q & smp_mid_q) | (smp_lo_q & rxd_s) | (smp_mid_q & rxd_s);
  assign decide = tick && (idx == SMP_HI) &&
                  (state_q == START || state_q == DATA || state_q == STOP);

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    tcnt_d     = tick ? idx : tcnt_q;
    bitcnt_d   = bitcnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d    = START;
          div_d      = '0;
          tcnt_d     = '0;
          bitcnt_d   = '0;
          idle_cnt_d = '0;
        end else if (tick && idle_cnt_q != IDLE_TOP) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      START: begin
        if (decide) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (maj) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    idle_d = (state_d == IDLE) && (idle_cnt_d == IDLE_TOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      div_q      <= '0;
      tcnt_q     <= '0;
      bitcnt_q   <= '0;
      idle_cnt_q <= '0;
      data_q     <= 8'h00;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      state_q    <= state_d;
      div_q      <= div_d;
      tcnt_q     <= tcnt_d;
      bitcnt_q   <= bitcnt_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      idle_q     <= idle_d;
    end
  end

  // Vote samples and the shift register are always written before they are read.
  always_ff @(posedge clk) begin
    if (tick && idx == SMP_LO)  smp_lo_q  <= rxd_s;
    if (tick && idx == SMP_MID) smp_mid_q <= rxd_s;
    if (decide && state_q == DATA) shift_q <= {maj, shift_q[7:1]};
  end

  assign rxd_data        = data_q;
  assign rxd_data_ready  = ready_q;
  assign rxd_framing_err = ferr_q;
  assign rxd_busy        = (state_q != IDLE);
  assign rxd_idle        = idle_q;

endmodule

// File: tb/tb_async_receiver.sv
// Scoreboard bench for async_receiver: a UART line model issues frames and queues expected events;
// per-DUT monitors pop and compare on every strobe.
module tb_async_receiver;

  logic       clk;
  logic       rst_n;
  logic       rxd1, rxd2;
  logic [7:0] data1, data2;
  logic       rdy1, rdy2, fe1, fe2, busy1, busy2, idle1, idle2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        q1[$];
  ev_t        q2[$];
  logic [7:0] lg1 = 8'h00;
  logic [7:0] lg2 = 8'h00;

  async_receiver #(.clk_freq(921600), .baud(115200), .oversampling(8), .idle_bits(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd1), .rxd_data(data1), .rxd_data_ready(rdy1),
    .rxd_framing_err(fe1), .rxd_busy(busy1), .rxd_idle(idle1));

  async_receiver #(.clk_freq(25000000), .baud(115200), .oversampling(8), .idle_bits(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd2), .rxd_data(data2), .rxd_data_ready(rdy2),
    .rxd_framing_err(fe2), .rxd_busy(busy2), .rxd_idle(idle2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic setline(input bit which, input logic v);
    if (which) rxd2 = v;
    else       rxd1 = v;
  endtask

  task automatic hold(input bit which, input logic v, input int n);
    setline(which, v);
    repeat (n) @(negedge clk);
  endtask

  // Sends start + 8 data bits LSB first + stop; a bad frame drives the stop bit low and leaves the line low.
  task automatic send(input bit which, input logic [7:0] b, input bit good, input int nstop, input real bitclk);
    logic [9:0] bits;
    int prev, tgt;
    bits = {good, b, 1'b0};
    if (!which) begin
      if (good) begin q1.push_back('{1'b0, b}); lg1 = b; end
      else q1.push_back('{1'b1, lg1});
    end else begin
      if (good) begin q2.push_back('{1'b0, b}); lg2 = b; end
      else q2.push_back('{1'b1, lg2});
    end
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      setline(which, bits[i]);
      tgt = $rtoi((i + 1) * bitclk + 0.5);
      repeat (tgt - prev) @(negedge clk);
      prev = tgt;
    end
    if (good && nstop > 1) hold(which, 1'b1, $rtoi((nstop - 1) * bitclk + 0.5));
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (rdy1 || fe1)) begin
      chk("d1_excl", {31'd0, rdy1 & fe1}, 32'd0);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected rdy=%0b ferr=%0b data=%0h required=no_event", rdy1, fe1, data1);
      end else begin
        e = q1.pop_front();
        chk("d1_kind_err", {31'd0, fe1}, {31'd0, e.err});
        chk(e.err ? "d1_data_held" : "d1_data", {24'd0, data1}, {24'd0, e.data});
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (rdy2 || fe2)) begin
      chk("d2_excl", {31'd0, rdy2 & fe2}, 32'd0);
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected rdy=%0b ferr=%0b data=%0h required=no_event", rdy2, fe2, data2);
      end else begin
        e = q2.pop_front();
        chk("d2_kind_err", {31'd0, fe2}, {31'd0, e.err});
        chk(e.err ? "d2_data_held" : "d2_data", {24'd0, data2}, {24'd0, e.data});
      end
    end
  end

  initial begin
    int bcnt, t0, tstop, trise;
    real bc2;
    logic [7:0] b;
    bit good;
    rxd1 = 1'b1; rxd2 = 1'b1; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", {24'd0, data1}, 32'h0);
    chk("rst_busy", {31'd0, busy1}, 32'h0);
    chk("rst_idle", {31'd0, idle1}, 32'h0);
    chk("rst_pulses", {30'd0, rdy1, fe1}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_after_reset", {31'd0, idle1}, 32'h1);

    // Single byte, two stop bits.
    fork
      send(1'b0, 8'hA5, 1'b1, 2, 8.0);
      begin
        repeat (40) @(negedge clk);
        chk("busy_mid_frame", {31'd0, busy1}, 32'h1);
        chk("idle_mid_frame", {31'd0, idle1}, 32'h0);
      end
    join
    hold(1'b0, 1'b1, 10);

    // Back-to-back, one stop bit.
    send(1'b0, 8'h00, 1'b1, 1, 8.0);
    send(1'b0, 8'hFF, 1'b1, 1, 8.0);
    send(1'b0, 8'h55, 1'b1, 1, 8.0);
    hold(1'b0, 1'b1, 10);

    // Framing error followed by a long break.
    send(1'b0, 8'h3C, 1'b0, 1, 8.0);
    hold(1'b0, 1'b0, 20 * 8);
    chk("busy_in_break", {31'd0, busy1}, 32'h1);
    hold(1'b0, 1'b1, 16);
    send(1'b0, 8'h96, 1'b1, 1, 8.0);
    hold(1'b0, 1'b1, 40);

    // Two-tick glitch on the idle line.
    hold(1'b0, 1'b0, 2);
    setline(1'b0, 1'b1);
    bcnt = 0;
    repeat (24) begin
      @(negedge clk);
      if (busy1) bcnt++;
    end
    chk("glitch_busy_seen", {31'd0, bcnt > 0}, 32'h1);
    chk("glitch_busy_short", {31'd0, bcnt < 8}, 32'h1);

    // Reset in the middle of a byte.
    hold(1'b0, 1'b0, 8);
    hold(1'b0, 1'b1, 8);
    hold(1'b0, 1'b1, 8);
    hold(1'b0, 1'b0, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_data", {24'd0, data1}, 32'h0);
    chk("midrst_busy", {31'd0, busy1}, 32'h0);
    chk("midrst_pulses", {30'd0, rdy1, fe1}, 32'h0);
    lg1 = 8'h00; lg2 = 8'h00;
    rxd1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 1'b1, 20);
    send(1'b0, 8'h81, 1'b1, 1, 8.0);
    hold(1'b0, 1'b1, 10);

    // Randomised traffic: mixed stop counts, gaps and framing errors.
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      send(1'b0, b, good, int'($urandom_range(1, 2)), 8.0);
      if (!good) begin
        hold(1'b0, 1'b0, int'($urandom_range(0, 3)) * 8);
        hold(1'b0, 1'b1, 8);
      end else begin
        hold(1'b0, 1'b1, int'($urandom_range(0, 12)));
      end
    end
    hold(1'b0, 1'b1, 40);

    // 25 MHz receiver, transmitter 2% fast.
    bc2 = 25000000.0 / 117504.0;
    t0 = cyc;
    send(1'b1, 8'h5A, 1'b1, 1, bc2);
    tstop = t0 + $rtoi(10.0 * bc2 + 0.5);
    chk("d2_idle_after_frame", {31'd0, idle2}, 32'h0);
    trise = -1;
    for (int k = 0; k < 4000 && trise < 0; k++) begin
      @(negedge clk);
      if (idle2) trise = cyc;
    end
    chk("d2_idle_rose", {31'd0, trise >= 0}, 32'h1);
    chk("d2_idle_window", {31'd0, (trise - tstop) >= $rtoi(9.0 * bc2) && (trise - tstop) <= $rtoi(11.0 * bc2)}, 32'h1);

    repeat (20) @(negedge clk);
    chk("q1_drained", q1.size(), 32'h0);
    chk("q2_drained", q2.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
